// File: rtl/bp_fe_fetch_replay_fifo.sv
// In-order fetch replay buffer: holds fetch requests until the I$ resolves them,
// rewinding issue on a miss. Define BP_FE_REPLAY_FIFO_PERF_EN for the replay counter.
module bp_fe_fetch_replay_fifo #(
  parameter int width_p     = 64,
  parameter int els_p       = 8,
  parameter int latency_p   = 2,
  parameter int ctr_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [width_p-1:0]         data_o,
  output logic                       v_o,
  input  logic                       yumi_i,
  input  logic                       ret_v_i,
  output logic                       poison_o,
  output logic [$clog2(els_p+1)-1:0] count_o,
  output logic [ctr_width_p-1:0]     replay_count_o
);

  localparam int idx_w_lp = $clog2(els_p);
  localparam int ptr_w_lp = idx_w_lp + 1;
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic [ptr_w_lp-1:0]  wptr_r, rptr_r, cptr_r, occ;
  logic [latency_p-1:0] inflight_r;
  logic [width_p-1:0]   mem_r [els_p];
  logic                 clear, resolve, commit, rollback, enq, issue;

  // Reset and flush share the same pointer/in-flight clearing path.
  assign clear    = reset_i | flush_i;
  assign occ      = wptr_r - cptr_r;
  assign ready_o  = (occ != ptr_w_lp'(els_p));
  assign count_o  = cnt_w_lp'(occ);

  assign resolve  = inflight_r[latency_p-1];
  assign commit   = resolve & ret_v_i;
  assign rollback = resolve & ~ret_v_i;

  assign v_o      = (rptr_r != wptr_r) & ~rollback;
  assign issue    = v_o & yumi_i & ~clear;
  assign enq      = v_i & ready_o & ~clear;
  assign poison_o = clear ? (|inflight_r) : rollback;
  assign data_o   = mem_r[rptr_r[idx_w_lp-1:0]];

  always_ff @(posedge clk_i) begin
    if (clear) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      cptr_r     <= '0;
      inflight_r <= '0;
    end else begin
      if (enq)
        wptr_r <= wptr_r + ptr_w_lp'(1);
      // A miss on the oldest in-flight entry rewinds issue to the commit point.
      if (rollback)
        rptr_r <= cptr_r;
      else if (issue)
        rptr_r <= rptr_r + ptr_w_lp'(1);
      if (commit)
        cptr_r <= cptr_r + ptr_w_lp'(1);
      inflight_r <= rollback ? '0 : ((inflight_r << 1) | latency_p'(issue));
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_r[wptr_r[idx_w_lp-1:0]] <= data_i;
  end

`ifdef BP_FE_REPLAY_FIFO_PERF_EN
  logic [ctr_width_p-1:0] replay_cnt_r;

  // Flush takes precedence over a coincident rollback, so it is not counted.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      replay_cnt_r <= '0;
    else if (rollback & ~flush_i & ~(&replay_cnt_r))
      replay_cnt_r <= replay_cnt_r + ctr_width_p'(1);
  end

  assign replay_count_o = replay_cnt_r;
`else
  assign replay_count_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!ret_v_i || resolve);
      assert (!yumi_i || v_o);
    end
  end

endmodule

// File: tb/tb_bp_fe_fetch_replay_fifo.sv
// Randomised and directed bench for bp_fe_fetch_replay_fifo against a queue-based model.
module tb_bp_fe_fetch_replay_fifo;

  localparam int W   = 16;
  localparam int ELS = 8;
  localparam int LAT = 2;
  localparam int CW  = 2;
`ifdef BP_FE_REPLAY_FIFO_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic          clk_i = 0;
  logic          reset_i, flush_i, v_i, yumi_i, ret_v_i;
  logic [W-1:0]  data_i;
  logic          ready_o, v_o, poison_o;
  logic [W-1:0]  data_o;
  logic [3:0]    count_o;
  logic [CW-1:0] replay_count_o;

  int tests = 0;
  int fails = 0;

  bp_fe_fetch_replay_fifo #(.width_p(W), .els_p(ELS), .latency_p(LAT), .ctr_width_p(CW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .data_i(data_i), .v_i(v_i),
    .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .ret_v_i(ret_v_i),
    .poison_o(poison_o), .count_o(count_o), .replay_count_o(replay_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: mq holds uncommitted payloads oldest first; pend holds the resolve
  // cycle of each issued, unresolved entry (always the oldest pend.size() of mq).
  logic [W-1:0] mq[$];
  int           pend[$];
  int           cyc = 0;
  int           m_rc = 0;
  logic         exp_resolving, exp_rollback, exp_v, exp_ready, exp_poison;
  logic [W-1:0] exp_data;
  logic [3:0]   exp_count;
  logic [CW-1:0] exp_rc;

  function automatic void model_eval();
    exp_resolving = (pend.size() > 0) && (pend[0] == cyc);
    exp_rollback  = exp_resolving && !ret_v_i;
    exp_v         = (mq.size() > pend.size()) && !exp_rollback;
    exp_data      = exp_v ? mq[pend.size()] : '0;
    exp_ready     = mq.size() < ELS;
    exp_count     = 4'(mq.size());
    exp_poison    = flush_i ? (pend.size() > 0) : exp_rollback;
    exp_rc        = (PERF != 0) ? CW'(m_rc) : '0;
  endfunction

  task automatic set_inputs(input logic v, input logic [W-1:0] d, input logic y,
                            input logic r, input logic f);
    v_i = v; data_i = d; flush_i = f; ret_v_i = 0; yumi_i = 0;
    model_eval();
    ret_v_i = r & exp_resolving;
    model_eval();
    yumi_i = y & exp_v;
    model_eval();
    #1;
  endtask

  task automatic tick();
    model_eval();
    if (reset_i) begin
      mq.delete(); pend.delete(); m_rc = 0;
    end else if (flush_i) begin
      mq.delete(); pend.delete();
    end else begin
      if (exp_resolving && ret_v_i) begin
        void'(mq.pop_front()); void'(pend.pop_front());
      end
      if (exp_rollback) begin
        pend.delete();
        if (m_rc < (1 << CW) - 1) m_rc++;
      end
      if (yumi_i && exp_v) pend.push_back(cyc + LAT);
      if (v_i && exp_ready) mq.push_back(data_i);
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear();
    set_inputs(0, '0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset();
    reset_i = 1;
    set_inputs(0, '0, 0, 0, 0); tick(); tick();
    reset_i = 0;
    set_inputs(0, '0, 0, 0, 0);
    tests++; if (ready_o !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b want 1", ready_o); end
    tests++; if (v_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_v: got %b want 0", v_o); end
    tests++; if (poison_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_poison: got %b want 0", poison_o); end
    tests++; if (count_o !== 4'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d want 0", count_o); end
    tests++; if (replay_count_o !== '0) begin fails++; $display("[TB] FAIL reset_replay: got %0d want 0", replay_count_o); end
  endtask

  task automatic test_basic_flow();
    logic [W-1:0] want;
    clear();
    for (int t = 0; t < 8; t++) begin
      set_inputs(t < 3, W'(16'hA000 + t), 1, 1, 0);
      if (t >= 1 && t <= 3) begin
        want = W'(16'hA000 + t - 1);
        tests++;
        if (v_o !== 1'b1 || data_o !== want) begin
          fails++; $display("[TB] FAIL basic_issue t=%0d: got v=%b d=%h want v=1 d=%h", t, v_o, data_o, want);
        end
      end
      tests++; if (count_o !== exp_count) begin fails++; $display("[TB] FAIL basic_count t=%0d: got %0d want %0d", t, count_o, exp_count); end
      tests++; if (poison_o !== 1'b0) begin fails++; $display("[TB] FAIL basic_poison t=%0d: got %b want 0", t, poison_o); end
      if (t == 6) begin
        tests++; if (count_o !== 4'd0) begin fails++; $display("[TB] FAIL basic_drained: got %0d want 0", count_o); end
      end
      tick();
    end
  endtask

  task automatic test_miss_replay();
    logic missed = 0;
    clear();
    for (int t = 0; t < 12; t++) begin
      set_inputs(t < 3, W'(16'hA000 + t), 1, missed, 0);
      if (t == 3) begin
        tests++; if (poison_o !== 1'b1 || v_o !== 1'b0) begin
          fails++; $display("[TB] FAIL miss_poison: got poison=%b v=%b want poison=1 v=0", poison_o, v_o); end
      end
      if (t == 4) begin
        tests++; if (v_o !== 1'b1 || data_o !== 16'hA000) begin
          fails++; $display("[TB] FAIL miss_reissue: got v=%b d=%h want v=1 d=a000", v_o, data_o); end
      end
      tests++; if (v_o !== exp_v || (exp_v && data_o !== exp_data)) begin
        fails++; $display("[TB] FAIL miss_issue t=%0d: got v=%b d=%h want v=%b d=%h", t, v_o, data_o, exp_v, exp_data); end
      tests++; if (count_o !== exp_count) begin fails++; $display("[TB] FAIL miss_count t=%0d: got %0d want %0d", t, count_o, exp_count); end
      missed |= exp_rollback;
      tick();
    end
    set_inputs(0, '0, 0, 0, 0);
    tests++; if (replay_count_o !== exp_rc) begin fails++; $display("[TB] FAIL miss_replay_cnt: got %0d want %0d", replay_count_o, exp_rc); end
  endtask

  task automatic test_full_wrap();
    int k = 0;
    clear();
    for (int t = 0; t < ELS; t++) begin set_inputs(1, W'(16'hB000 + t), 0, 0, 0); tick(); end
    set_inputs(1, 16'hDEAD, 0, 0, 0);
    tests++; if (ready_o !== 1'b0) begin fails++; $display("[TB] FAIL full_ready: got %b want 0", ready_o); end
    tests++; if (count_o !== 4'd8) begin fails++; $display("[TB] FAIL full_count: got %0d want 8", count_o); end
    tick();
    set_inputs(0, '0, 1, 1, 0); tick();
    set_inputs(0, '0, 0, 1, 0); tick();
    set_inputs(0, '0, 0, 1, 0);
    tests++; if (ready_o !== 1'b0) begin fails++; $display("[TB] FAIL full_commit_same_cycle: got ready=%b want 0", ready_o); end
    tick();
    set_inputs(0, '0, 0, 0, 0);
    tests++; if (ready_o !== 1'b1 || count_o !== 4'd7) begin
      fails++; $display("[TB] FAIL full_after_commit: got ready=%b cnt=%0d want ready=1 cnt=7", ready_o, count_o); end
    for (int t = 0; t < 60; t++) begin
      set_inputs(1, W'(16'hC000 + k), 1, 1, 0);
      tests++; if (v_o !== exp_v || (exp_v && data_o !== exp_data)) begin
        fails++; $display("[TB] FAIL wrap_order t=%0d: got v=%b d=%h want v=%b d=%h", t, v_o, data_o, exp_v, exp_data); end
      tests++; if (count_o !== exp_count || ready_o !== exp_ready) begin
        fails++; $display("[TB] FAIL wrap_count t=%0d: got cnt=%0d rdy=%b want cnt=%0d rdy=%b", t, count_o, ready_o, exp_count, exp_ready); end
      if (exp_ready) k++;
      tick();
    end
  endtask

  task automatic test_flush();
    clear();
    for (int t = 0; t < 6; t++) begin set_inputs(1, W'(16'hE000 + t), 0, 0, 0); tick(); end
    set_inputs(0, '0, 1, 1, 0); tick();
    set_inputs(1, 16'hEEEE, 1, 1, 1);
    tests++; if (poison_o !== 1'b1) begin fails++; $display("[TB] FAIL flush_poison: got %b want 1", poison_o); end
    tick();
    set_inputs(0, '0, 0, 0, 0);
    tests++; if (v_o !== 1'b0 || count_o !== 4'd0 || ready_o !== 1'b1) begin
      fails++; $display("[TB] FAIL flush_state: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", v_o, count_o, ready_o); end
  endtask

  task automatic test_simultaneous();
    logic [CW-1:0] rc_save;
    clear();
    set_inputs(1, 16'h1111, 0, 0, 0); tick();
    set_inputs(0, '0, 1, 0, 0); tick();
    set_inputs(0, '0, 0, 0, 0); tick();
    set_inputs(1, 16'h5555, 0, 0, 0);
    tests++; if (poison_o !== 1'b1 || v_o !== 1'b0) begin
      fails++; $display("[TB] FAIL rb_enq_poison: got poison=%b v=%b want poison=1 v=0", poison_o, v_o); end
    tick();
    set_inputs(0, '0, 1, 0, 0);
    tests++; if (count_o !== 4'd2 || data_o !== 16'h1111) begin
      fails++; $display("[TB] FAIL rb_enq_count: got cnt=%0d d=%h want cnt=2 d=1111", count_o, data_o); end
    tick();
    set_inputs(0, '0, 0, 0, 0); tick();
    set_inputs(0, '0, 0, 0, 1);
    rc_save = exp_rc;
    tests++; if (poison_o !== 1'b1) begin fails++; $display("[TB] FAIL rb_flush_poison: got %b want 1", poison_o); end
    tick();
    set_inputs(0, '0, 0, 0, 0);
    tests++; if (v_o !== 1'b0 || count_o !== 4'd0 || replay_count_o !== rc_save) begin
      fails++; $display("[TB] FAIL rb_flush_state: got v=%b cnt=%0d rc=%0d want v=0 cnt=0 rc=%0d", v_o, count_o, replay_count_o, rc_save); end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] want;
    want = (PERF != 0) ? CW'(3) : CW'(0);
    clear();
    set_inputs(1, 16'h7777, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      set_inputs(0, '0, 1, 0, 0); tick();
      set_inputs(0, '0, 0, 0, 0); tick();
      set_inputs(0, '0, 0, 0, 0); tick();
    end
    set_inputs(0, '0, 0, 0, 0);
    tests++; if (replay_count_o !== want) begin fails++; $display("[TB] FAIL sat_replay: got %0d want %0d", replay_count_o, want); end
    set_inputs(1, 16'h8888, 1, 0, 0); tick();
    reset_i = 1;
    set_inputs(0, '0, 0, 0, 0); tick();
    reset_i = 0;
    set_inputs(0, '0, 0, 0, 0);
    tests++; if (count_o !== 4'd0 || v_o !== 1'b0 || replay_count_o !== '0 || ready_o !== 1'b1) begin
      fails++; $display("[TB] FAIL midop_reset: got cnt=%0d v=%b rc=%0d rdy=%b want 0 0 0 1", count_o, v_o, replay_count_o, ready_o); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      set_inputs($urandom_range(0, 1), W'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      tests++; if (v_o !== exp_v || (exp_v && data_o !== exp_data)) begin
        fails++; $display("[TB] FAIL rand_issue t=%0d: got v=%b d=%h want v=%b d=%h", t, v_o, data_o, exp_v, exp_data); end
      tests++; if (ready_o !== exp_ready || count_o !== exp_count) begin
        fails++; $display("[TB] FAIL rand_occ t=%0d: got rdy=%b cnt=%0d want rdy=%b cnt=%0d", t, ready_o, count_o, exp_ready, exp_count); end
      tests++; if (poison_o !== exp_poison || replay_count_o !== exp_rc) begin
        fails++; $display("[TB] FAIL rand_poison t=%0d: got p=%b rc=%0d want p=%b rc=%0d", t, poison_o, replay_count_o, exp_poison, exp_rc); end
      tick();
    end
  endtask

  initial begin
    reset_i = 1; flush_i = 0; v_i = 0; yumi_i = 0; ret_v_i = 0; data_i = '0;
    @(posedge clk_i); #1;
    test_reset();
    test_basic_flow();
    test_miss_replay();
    test_full_wrap();
    test_flush();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_fe_fetch_replay_fifo.md
# bp_fe_fetch_replay_fifo

Parametrised in-order fetch replay buffer for the front end, sitting between the fetch-address source and the I$ request port. Entries are held until the I$ returns data for them; a miss on the oldest in-flight entry rewinds issue back to that entry and poisons younger in-flight requests. Depth, payload width and I$ pipeline latency are parameters, with flush and occupancy reporting.

## Interface
- `width_p`, default 64: payload bits per entry (vaddr, ptag, uncached, nonidem packed by the user).
- `els_p`, default 8: entries; power of two, ≥2.
- `latency_p`, default 2: cycles from issue handshake to I$ resolution; ≥1.
- `ctr_width_p`, default 16: replay counter width.
- `clk_i` in 1: clock; single clock domain.
- `reset_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: discard all entries and in-flight state.
- `data_i` in `width_p`: enqueue payload.
- `v_i` in 1: enqueue valid.
- `ready_o` out 1: not full; ready-and handshake, enqueue when `v_i & ready_o`.
- `data_o` out `width_p`: entry at issue pointer.
- `v_o` out 1: issue entry valid.
- `yumi_i` in 1: I$ accepts issue; legal only when `v_o`.
- `ret_v_i` in 1: I$ returned data for the resolving entry (I$ `data_v_o`).
- `poison_o` out 1: kill all younger in-flight I$ requests this cycle.
- `count_o` out `$clog2(els_p+1)`: valid entries (uncommitted).
- `replay_count_o` out `ctr_width_p`: saturating count of rollbacks.

## Operation
- Three pointers, each `$clog2(els_p)+1` bits with wrap bit: write `wptr`, issue `rptr`, commit `cptr`. Invariant cptr ≤ rptr ≤ wptr (modular).
- Full: `wptr - cptr == els_p`. Issue-empty: `rptr == wptr`.
- Enqueue: `v_i & ready_o` writes `data_i` at `wptr`, `wptr++`.
- Issue: `v_o = (rptr != wptr) & ~rollback`; `v_o & yumi_i` → `rptr++`, shifts 1 into `inflight_r[latency_p-1:0]`; otherwise shifts 0.
- Resolution when `inflight_r[latency_p-1]`:
  - `ret_v_i=1`: commit, `cptr++`, slot freed.
  - `ret_v_i=0`: rollback. Next state `rptr = cptr`, `inflight_r` cleared, `poison_o=1` combinationally this cycle, replay counter +1 (saturating).
- `ret_v_i` with no resolving entry: protocol violation, flagged by assertion, ignored.
- Storage is a 1r1w register array read at `rptr`. There is no enqueue→issue bypass.
- Flush: highest priority. Next state: all pointers 0, `inflight_r` 0. Enqueue, issue and commit that cycle are ignored. `poison_o=1` if any in-flight bit is set. Replay counter is unchanged.

## Timing
- Reset values: `ready_o=1`, `v_o=0`, `poison_o=0`, `count_o=0`, `replay_count_o=0`. `data_o` is meaningful only with `v_o`.
- Enqueue into an empty FIFO at cycle t: `v_o=1` at t+1.
- Issue at cycle t: resolves at t+`latency_p`.
- Rollback at cycle r: `v_o=0` at r. Re-issue of the same entry is possible at r+1. Minimum replay penalty is `latency_p+1` cycles.
- `ready_o` and `count_o` come from registered pointers. A commit in cycle t frees a slot at t+1; there is no same-cycle full-bypass.
- Enqueue and commit in the same cycle are legal; `count_o` is unchanged.
- Rollback and enqueue in the same cycle: enqueue succeeds.
- Rollback and flush in the same cycle: flush wins.
- Pointer wrap: modular arithmetic. Full and empty are distinguished by the wrap bit.
- Reset mid-operation behaves exactly like flush and additionally clears `replay_count_o`.

## Configuration
- `BP_FE_REPLAY_FIFO_PERF_EN` defined: `replay_count_o` is live, saturating at `2^ctr_width_p-1`.
- Not defined: no counter flops; `replay_count_o` is tied to 0. All other behaviour is identical.

## Test plan
- Basic flow, `latency_p=2`: enqueue A,B,C back-to-back, hold `yumi_i=1`, `ret_v_i=1` on every resolution → issue A,B,C at cycles 1,2,3; commits at 3,4,5; `count_o` returns to 0 at cycle 6.
- Miss replay: same stream, `ret_v_i=0` when A resolves at cycle 3 → `poison_o=1` at 3; `v_o=0` at 3; `data_o=A` with `v_o=1` at 4; B is not committed before A; `replay_count_o=1` (PERF_EN).
- Full boundary, `els_p=8`: enqueue 8 with `yumi_i=0` → `ready_o=0`, `count_o=8`. Issue one and commit → `ready_o=1` one cycle after commit. Run 20 enqueue/commit pairs to exercise pointer wrap; output order is preserved.
- Flush with 3 in flight and 5 queued → `poison_o=1`; next cycle `v_o=0`, `count_o=0`, `ready_o=1`. A same-cycle `v_i` is dropped.
- Simultaneous events: rollback cycle with `v_i=1` → entry is accepted and `count_o` increments. Rollback plus flush → flush result only.
- Saturation (PERF_EN, `ctr_width_p=2`): 5 rollbacks → `replay_count_o=3`. With the macro off → always 0.
